// File: rtl/fft_mdc_pkg.sv
// Shared types and helpers for the MDC FFT pipeline stages.
// Holds the default sample width, the complex sample struct and a log2 helper.
package fft_mdc_pkg;

    localparam int MDC_WIDTH = 9;

    typedef struct packed {
        logic signed [MDC_WIDTH-1:0] re;
        logic signed [MDC_WIDTH-1:0] im;
    } cplx_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mdc_delay_line.sv
// DEPTH-word shift register with enable and async reset; q is the word
// written DEPTH enabled cycles ago. DEPTH=1 is a single register.
module mdc_delay_line #(
    parameter int W     = 18,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
            mem[0] <= d;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign q = mem[DEPTH-1];

endmodule

// File: rtl/mdc_delay_commutator.sv
// Radix-2 MDC delay-commutator: upper delay, swap commutator, lower delay.
// Optional straight pass-through mode when MDC_COM_BYPASS_EN is defined.
module mdc_delay_commutator
    import fft_mdc_pkg::*;
#(
    parameter int WIDTH = MDC_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sync,
`ifdef MDC_COM_BYPASS_EN
    input  logic                    bypass,
`endif
    input  logic signed [WIDTH-1:0] inUI_re,
    input  logic signed [WIDTH-1:0] inUI_im,
    input  logic signed [WIDTH-1:0] inLI_re,
    input  logic signed [WIDTH-1:0] inLI_im,
    output logic                    out_valid,
    output logic                    out_sync,
    output logic signed [WIDTH-1:0] Up_out_re,
    output logic signed [WIDTH-1:0] Up_out_im,
    output logic signed [WIDTH-1:0] Low_out_re,
    output logic signed [WIDTH-1:0] Low_out_im
);

    localparam int CW = clog2(2 * DEPTH);
    localparam int SB = clog2(DEPTH);
    localparam int WW = clog2(DEPTH + 1);
    localparam logic [CW-1:0] D_CNT  = CW'(DEPTH);
    localparam logic [WW-1:0] D_WARM = WW'(DEPTH);

    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } sample_t;

    sample_t u_in, l_in, u_del, l_del, cu, cl;
    sample_t up_q, low_q;

    logic          run;
    logic [CW-1:0] cnt, n_eff;
    logic [WW-1:0] warm, warm_eff;
    logic          swap, warm_done, frame_start;

    assign u_in = '{re: inUI_re, im: inUI_im};
    assign l_in = '{re: inLI_re, im: inLI_im};

`ifdef MDC_COM_BYPASS_EN
    assign run = in_valid && !bypass;
`else
    assign run = in_valid;
`endif

    // An accepted sync pair is n=0 regardless of the stored counter values.
    always_comb begin
        n_eff       = in_sync ? '0 : cnt;
        warm_eff    = in_sync ? '0 : warm;
        swap        = n_eff[SB];
        warm_done   = (warm_eff == D_WARM);
        frame_start = warm_done && (n_eff == D_CNT);
        cu          = swap ? l_in  : u_del;
        cl          = swap ? u_del : l_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            warm <= '0;
        end else if (run) begin
            cnt  <= n_eff + 1'b1;
            warm <= warm_done ? warm_eff : warm_eff + 1'b1;
        end
    end

    mdc_delay_line #(.W(2 * WIDTH), .DEPTH(DEPTH)) u_upper_dl (
        .clk (clk),
        .rst (rst),
        .en  (run),
        .d   (u_in),
        .q   (u_del)
    );

    mdc_delay_line #(.W(2 * WIDTH), .DEPTH(DEPTH)) u_lower_dl (
        .clk (clk),
        .rst (rst),
        .en  (run),
        .d   (cl),
        .q   (l_del)
    );

    // Data registers hold when nothing is emitted; only the strobes drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sync  <= 1'b0;
            up_q      <= '0;
            low_q     <= '0;
        end else begin
            out_valid <= 1'b0;
            out_sync  <= 1'b0;
`ifdef MDC_COM_BYPASS_EN
            if (bypass) begin
                if (in_valid) begin
                    out_valid <= 1'b1;
                    out_sync  <= in_sync;
                    up_q      <= u_in;
                    low_q     <= l_in;
                end
            end else
`endif
            if (run && warm_done) begin
                out_valid <= 1'b1;
                out_sync  <= frame_start;
                up_q      <= cu;
                low_q     <= l_del;
            end
        end
    end

    assign Up_out_re  = up_q.re;
    assign Up_out_im  = up_q.im;
    assign Low_out_re = low_q.re;
    assign Low_out_im = low_q.im;

endmodule

// File: tb/tb_mdc_delay_commutator.sv
// Self-checking bench for mdc_delay_commutator at DEPTH 2, 1 and 16 in parallel.
// Bypass scenario is exercised only when MDC_COM_BYPASS_EN is defined.
module tb_mdc_delay_commutator;

    localparam int NDUT = 3;
    localparam int DEPTHS [NDUT] = '{2, 1, 16};

    typedef struct packed {
        logic signed [8:0] ure;
        logic signed [8:0] uim;
        logic signed [8:0] lre;
        logic signed [8:0] lim;
    } smp_t;

    logic clk, rst, in_valid, in_sync;
    logic signed [8:0] u_re, u_im, l_re, l_im;
`ifdef MDC_COM_BYPASS_EN
    logic bypass;
`endif
    bit byp;

    logic              ov [NDUT];
    logic              os [NDUT];
    logic signed [8:0] up_re [NDUT];
    logic signed [8:0] up_im [NDUT];
    logic signed [8:0] lo_re [NDUT];
    logic signed [8:0] lo_im [NDUT];

    smp_t              hist [NDUT][$];
    logic              e_v  [NDUT];
    logic              e_s  [NDUT];
    logic signed [8:0] e_ur [NDUT];
    logic signed [8:0] e_ui [NDUT];
    logic signed [8:0] e_lr [NDUT];
    logic signed [8:0] e_li [NDUT];

    int checks = 0;
    int passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mdc_delay_commutator #(.WIDTH(9), .DEPTH(2)) dut_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
`ifdef MDC_COM_BYPASS_EN
        .bypass(bypass),
`endif
        .inUI_re(u_re), .inUI_im(u_im), .inLI_re(l_re), .inLI_im(l_im),
        .out_valid(ov[0]), .out_sync(os[0]),
        .Up_out_re(up_re[0]), .Up_out_im(up_im[0]),
        .Low_out_re(lo_re[0]), .Low_out_im(lo_im[0])
    );

    mdc_delay_commutator #(.WIDTH(9), .DEPTH(1)) dut_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
`ifdef MDC_COM_BYPASS_EN
        .bypass(bypass),
`endif
        .inUI_re(u_re), .inUI_im(u_im), .inLI_re(l_re), .inLI_im(l_im),
        .out_valid(ov[1]), .out_sync(os[1]),
        .Up_out_re(up_re[1]), .Up_out_im(up_im[1]),
        .Low_out_re(lo_re[1]), .Low_out_im(lo_im[1])
    );

    mdc_delay_commutator #(.WIDTH(9), .DEPTH(16)) dut_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
`ifdef MDC_COM_BYPASS_EN
        .bypass(bypass),
`endif
        .inUI_re(u_re), .inUI_im(u_im), .inLI_re(l_re), .inLI_im(l_im),
        .out_valid(ov[2]), .out_sync(os[2]),
        .Up_out_re(up_re[2]), .Up_out_im(up_im[2]),
        .Low_out_re(lo_re[2]), .Low_out_im(lo_im[2])
    );

    // Reference model: keeps every pair of the current stream and evaluates
    // the commutator equations directly by sample index.
    task automatic model_step(input bit v, input bit s, input smp_t x);
        int n, k, dd;
        for (int d = 0; d < NDUT; d++) begin
            e_v[d] = 1'b0;
            e_s[d] = 1'b0;
            if (byp) begin
                if (v) begin
                    e_v[d] = 1'b1;
                    e_s[d] = s;
                    e_ur[d] = x.ure; e_ui[d] = x.uim;
                    e_lr[d] = x.lre; e_li[d] = x.lim;
                end
            end else if (v) begin
                if (s) hist[d].delete();
                hist[d].push_back(x);
                n  = hist[d].size() - 1;
                dd = DEPTHS[d];
                if (n >= dd) begin
                    e_v[d] = 1'b1;
                    e_s[d] = (((n - dd) % (2 * dd)) == 0);
                    if ((n % (2 * dd)) >= dd) begin
                        e_ur[d] = hist[d][n].lre; e_ui[d] = hist[d][n].lim;
                    end else begin
                        e_ur[d] = hist[d][n-dd].ure; e_ui[d] = hist[d][n-dd].uim;
                    end
                    k = n - dd;
                    if ((k % (2 * dd)) >= dd) begin
                        e_lr[d] = hist[d][k-dd].ure; e_li[d] = hist[d][k-dd].uim;
                    end else begin
                        e_lr[d] = hist[d][k].lre; e_li[d] = hist[d][k].lim;
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            hist[d].delete();
            e_v[d] = 1'b0; e_s[d] = 1'b0;
            e_ur[d] = '0; e_ui[d] = '0; e_lr[d] = '0; e_li[d] = '0;
        end
    endtask

    task automatic cycle(input bit v, input bit s, input logic signed [8:0] ur, ui, lr, li);
        smp_t x;
        @(negedge clk);
        in_valid = v; in_sync = s;
        u_re = ur; u_im = ui; l_re = lr; l_im = li;
`ifdef MDC_COM_BYPASS_EN
        bypass = byp;
`endif
        x = '{ure: ur, uim: ui, lre: lr, lim: li};
        model_step(v, s, x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; byp = 1'b0;
        u_re = '0; u_im = '0; l_re = '0; l_im = '0;
`ifdef MDC_COM_BYPASS_EN
        bypass = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({ov[d], os[d], up_re[d], up_im[d], lo_re[d], lo_im[d]} !== 38'd0)
                $display("FAIL reset d=%0d: got v=%b s=%b up=%0d/%0d low=%0d/%0d, expected all zero",
                         DEPTHS[d], ov[d], os[d], up_re[d], up_im[d], lo_re[d], lo_im[d]);
            else passes++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Fixed D=2 stream with literal expected values; gap=1 inserts idle cycles.
    task automatic test_stream(input string name, input bit gap);
        int up_t [8] = '{0, 0, 18, 19, 2, 3, 22, 23};
        int lo_t [8] = '{0, 0, 16, 17, 0, 1, 20, 21};
        logic signed [8:0] a, b;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            if (gap && n > 0) begin
                cycle(1'b0, 1'($urandom), 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom));
                checks++;
                if (ov[0] !== 1'b0 || os[0] !== 1'b0)
                    $display("FAIL %s_gap n=%0d: got v=%b s=%b, expected v=0 s=0", name, n, ov[0], os[0]);
                else passes++;
            end
            a = 9'(n); b = 9'(16 + n);
            cycle(1'b1, n == 0, a, -a, b, -b);
            checks++;
            if ({ov[0], os[0], up_re[0], up_im[0], lo_re[0], lo_im[0]} !==
                {n >= 2, (n == 2) || (n == 6), 9'(up_t[n]), 9'(-up_t[n]), 9'(lo_t[n]), 9'(-lo_t[n])})
                $display("FAIL %s_table n=%0d: got v=%b s=%b up=%0d/%0d low=%0d/%0d, expected v=%b s=%b up=%0d low=%0d",
                         name, n, ov[0], os[0], up_re[0], up_im[0], lo_re[0], lo_im[0],
                         n >= 2, (n == 2) || (n == 6), up_t[n], lo_t[n]);
            else passes++;
            for (int d = 1; d < NDUT; d++) begin
                checks++;
                if ({ov[d], os[d], up_re[d], up_im[d], lo_re[d], lo_im[d]} !==
                    {e_v[d], e_s[d], e_ur[d], e_ui[d], e_lr[d], e_li[d]})
                    $display("FAIL %s_model d=%0d n=%0d: got v=%b s=%b up=%0d low=%0d, expected v=%b s=%b up=%0d low=%0d",
                             name, DEPTHS[d], n, ov[d], os[d], up_re[d], lo_re[d], e_v[d], e_s[d], e_ur[d], e_lr[d]);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [8:0] a;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            a = 9'(n);
            cycle(1'b1, n == 0, a, -a, a + 9'sd16, -a - 9'sd16);
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_sync = 1'b0;
        for (int r = 0; r < 2; r++) begin
            #1;
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if ({ov[d], os[d], up_re[d], up_im[d], lo_re[d], lo_im[d]} !== 38'd0)
                    $display("FAIL reset_mid d=%0d phase=%0d: got v=%b s=%b up=%0d low=%0d, expected all zero",
                             DEPTHS[d], r, ov[d], os[d], up_re[d], lo_re[d]);
                else passes++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        model_reset();
        for (int n = 0; n < 6; n++) begin
            a = 9'(40 + n);
            cycle(1'b1, 1'b0, a, -a, a + 9'sd50, -a - 9'sd50);
            checks++;
            if (ov[0] !== (n >= 2))
                $display("FAIL reset_resume_valid n=%0d: got %b, expected %b", n, ov[0], n >= 2);
            else passes++;
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if ({ov[d], os[d], up_re[d], up_im[d], lo_re[d], lo_im[d]} !==
                    {e_v[d], e_s[d], e_ur[d], e_ui[d], e_lr[d], e_li[d]})
                    $display("FAIL reset_resume d=%0d n=%0d: got v=%b s=%b up=%0d low=%0d, expected v=%b s=%b up=%0d low=%0d",
                             DEPTHS[d], n, ov[d], os[d], up_re[d], lo_re[d], e_v[d], e_s[d], e_ur[d], e_lr[d]);
                else passes++;
            end
        end
    endtask

    task automatic test_resync();
        logic signed [8:0] a;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            a = 9'(i);
            cycle(1'b1, (i == 0) || (i == 5), a, -a, a + 9'sd16, -a - 9'sd16);
            checks++;
            if (ov[0] !== (((i >= 2) && (i < 5)) || (i >= 7)))
                $display("FAIL resync_valid i=%0d: got %b, expected %b", i, ov[0],
                         ((i >= 2) && (i < 5)) || (i >= 7));
            else passes++;
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if ({ov[d], os[d], up_re[d], up_im[d], lo_re[d], lo_im[d]} !==
                    {e_v[d], e_s[d], e_ur[d], e_ui[d], e_lr[d], e_li[d]})
                    $display("FAIL resync d=%0d i=%0d: got v=%b s=%b up=%0d low=%0d, expected v=%b s=%b up=%0d low=%0d",
                             DEPTHS[d], i, ov[d], os[d], up_re[d], lo_re[d], e_v[d], e_s[d], e_ur[d], e_lr[d]);
                else passes++;
            end
        end
    endtask

    // Random data and valid gaps; sync on idle cycles must be ignored.
    task automatic test_random();
        int accepted = 0;
        bit v, s;
        do_reset();
        for (int cyc = 0; cyc < 400 && accepted < 120; cyc++) begin
            v = (accepted == 0) || ($urandom_range(0, 3) != 0);
            s = v ? (accepted == 0) : 1'($urandom);
            cycle(v, s, 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom));
            if (v) accepted++;
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if ({ov[d], os[d], up_re[d], up_im[d], lo_re[d], lo_im[d]} !==
                    {e_v[d], e_s[d], e_ur[d], e_ui[d], e_lr[d], e_li[d]})
                    $display("FAIL random d=%0d acc=%0d: got v=%b s=%b up=%0d/%0d low=%0d/%0d, expected v=%b s=%b up=%0d/%0d low=%0d/%0d",
                             DEPTHS[d], accepted, ov[d], os[d], up_re[d], up_im[d], lo_re[d], lo_im[d],
                             e_v[d], e_s[d], e_ur[d], e_ui[d], e_lr[d], e_li[d]);
                else passes++;
            end
        end
        checks++;
        if (accepted < 120) $display("FAIL random_budget: accepted %0d, required 120", accepted);
        else passes++;
    endtask

`ifdef MDC_COM_BYPASS_EN
    // Pass-through, then resume the interrupted stream to prove counters froze.
    task automatic test_bypass();
        bit v;
        logic signed [8:0] a;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            a = 9'(n);
            cycle(1'b1, n == 0, a, -a, a + 9'sd16, -a - 9'sd16);
        end
        byp = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = (i != 3);
            cycle(v, (i == 2), 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom));
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if ({ov[d], os[d], up_re[d], up_im[d], lo_re[d], lo_im[d]} !==
                    {e_v[d], e_s[d], e_ur[d], e_ui[d], e_lr[d], e_li[d]})
                    $display("FAIL bypass d=%0d i=%0d: got v=%b s=%b up=%0d low=%0d, expected v=%b s=%b up=%0d low=%0d",
                             DEPTHS[d], i, ov[d], os[d], up_re[d], lo_re[d], e_v[d], e_s[d], e_ur[d], e_lr[d]);
                else passes++;
            end
        end
        byp = 1'b0;
        for (int n = 5; n < 12; n++) begin
            a = 9'(n);
            cycle(1'b1, 1'b0, a, -a, a + 9'sd16, -a - 9'sd16);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if ({ov[d], os[d], up_re[d], up_im[d], lo_re[d], lo_im[d]} !==
                    {e_v[d], e_s[d], e_ur[d], e_ui[d], e_lr[d], e_li[d]})
                    $display("FAIL bypass_release d=%0d n=%0d: got v=%b s=%b up=%0d low=%0d, expected v=%b s=%b up=%0d low=%0d",
                             DEPTHS[d], n, ov[d], os[d], up_re[d], lo_re[d], e_v[d], e_s[d], e_ur[d], e_lr[d]);
                else passes++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream("plan", 1'b0);
        test_stream("gaps", 1'b1);
        test_reset_mid();
        test_resync();
        test_random();
`ifdef MDC_COM_BYPASS_EN
        test_bypass();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
